stack_unit: RTL and testbench

- LIFO operand stack for the multi-cycle stack-based processor.
- It is the responder to the controller's push/pop/tos strobes.
- It holds the operands; the datapath's A and B registers load from its registered read port, and ALU results or memory data are pushed onto it.
- Single-cycle command acceptance; at most one command class executes per cycle.

---
 rtl/stack_unit.sv | 115 +++++++++++
 tb/tb_stack_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// LIFO operand stack with registered read port and sticky overflow/underflow flags.
// Define STACK_CIRC_EN to make a full-stack push overwrite the oldest entry instead of being refused.
module stack_unit #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      sp_q, sp_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [AW-1:0]    base, top_idx, wr_idx, wa;
    logic [WIDTH-1:0] top_data;
    logic             we, is_empty, is_full;

`ifdef STACK_CIRC_EN
    logic [AW-1:0] bp_q, bp_d;
    assign base = bp_q;
`else
    assign base = '0;
`endif

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SP_FULL);
    // Low AW bits of sp wrap to 0 when full, so wr_idx is also the oldest slot then.
    assign top_idx  = base + sp_q[AW-1:0] - IDX_ONE;
    assign wr_idx   = base + sp_q[AW-1:0];
    assign top_data = mem_q[top_idx];

    always_comb begin
        sp_d   = sp_q;
        dout_d = dout_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        we     = 1'b0;
        wa     = wr_idx;
`ifdef STACK_CIRC_EN
        bp_d   = bp_q;
`endif
        if (push && pop && !is_empty) begin
            we     = 1'b1;
            wa     = top_idx;
            dout_d = top_data;
        end else if (push) begin
            if (tos && !is_empty) dout_d = top_data;
            if (!is_full) begin
                we   = 1'b1;
                sp_d = sp_q + SP_ONE;
            end else begin
                ovf_d = 1'b1;
`ifdef STACK_CIRC_EN
                we    = 1'b1;
                bp_d  = bp_q + IDX_ONE;
`endif
            end
        end else if (pop || tos) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                dout_d = top_data;
                if (pop) sp_d = sp_q - SP_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
`ifdef STACK_CIRC_EN
            bp_q   <= '0;
`endif
        end else begin
            sp_q   <= sp_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
`ifdef STACK_CIRC_EN
            bp_q   <= bp_d;
`endif
        end
    end

    // Storage is never cleared; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (rst && we) mem_q[wa] <= din;
    end

    assign dout      = dout_q;
    assign count     = sp_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: stimulus queues hand-computed expectations,
// a monitor compares them one cycle after each issued command.
module tb_stack_unit;
    logic       clk = 1'b0;
    logic       rst, push, pop, tos;
    logic [7:0] din;
    logic [7:0] dout;
    logic [4:0] count;
    logic       empty, full, overflow, underflow;

    typedef struct {
        logic [7:0] dout;
        int         cnt;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t q[$];
    logic cmd_v = 1'b0;
    int   checks = 0;
    int   failures = 0;

    stack_unit dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
        .dout(dout), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic cmd(input logic r, input logic pu, input logic po, input logic to,
                       input logic [7:0] d, input logic [7:0] ed, input int ec,
                       input logic eo, input logic eu);
        exp_t e;
        @(negedge clk);
        rst = r; push = pu; pop = po; tos = to; din = d; cmd_v = 1'b1;
        e.dout = ed; e.cnt = ec; e.ovf = eo; e.unf = eu;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0; din = 8'h00; cmd_v = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        logic v;
        forever begin
            @(posedge clk);
            v = cmd_v;
            @(negedge clk);
            if (v) begin
                if (q.size() == 0) begin
                    chk("queue_underrun", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("dout", int'(dout), int'(e.dout));
                    chk("count", int'(count), e.cnt);
                    chk("empty", int'(empty), int'(e.cnt == 0));
                    chk("full", int'(full), int'(e.cnt == 16));
                    chk("overflow", int'(overflow), int'(e.ovf));
                    chk("underflow", int'(underflow), int'(e.unf));
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] exp_top;
        rst = 1'b0; push = 1'b0; pop = 1'b0; tos = 1'b0; din = 8'h00;
        repeat (2) @(posedge clk);

        // reset, push three, tos
        cmd(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        cmd(1, 1, 0, 0, 8'h11, 8'h00, 1, 0, 0);
        cmd(1, 1, 0, 0, 8'h22, 8'h00, 2, 0, 0);
        cmd(1, 1, 0, 0, 8'h33, 8'h00, 3, 0, 0);
        cmd(1, 0, 0, 1, 8'h00, 8'h33, 3, 0, 0);
        // drain in LIFO order
        cmd(1, 0, 1, 0, 8'h00, 8'h33, 2, 0, 0);
        cmd(1, 0, 1, 0, 8'h00, 8'h22, 1, 0, 0);
        cmd(1, 0, 1, 0, 8'h00, 8'h11, 0, 0, 0);
        // pop on empty, then push keeps underflow sticky
        cmd(1, 0, 1, 0, 8'h00, 8'h11, 0, 0, 1);
        cmd(1, 1, 0, 0, 8'h05, 8'h11, 1, 0, 1);

        // fill, overflow, replace-top while full, then drain all sixteen
        cmd(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 16; i++) cmd(1, 1, 0, 0, 8'(i), 8'h00, i, 0, 0);
        cmd(1, 1, 0, 0, 8'hAA, 8'h00, 16, 1, 0);
`ifdef STACK_CIRC_EN
        exp_top = 8'hAA;
`else
        exp_top = 8'h10;
`endif
        cmd(1, 1, 1, 0, 8'hBB, exp_top, 16, 1, 0);
        for (int i = 0; i < 16; i++) begin
`ifdef STACK_CIRC_EN
            exp_top = (i == 0) ? 8'hBB : 8'(17 - i);
`else
            exp_top = (i == 0) ? 8'hBB : 8'(16 - i);
`endif
            cmd(1, 0, 1, 0, 8'h00, exp_top, 15 - i, 1, 0);
        end

        // replace-top, push+tos, pop+tos
        cmd(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        cmd(1, 1, 0, 0, 8'h07, 8'h00, 1, 0, 0);
        cmd(1, 1, 0, 0, 8'h09, 8'h00, 2, 0, 0);
        cmd(1, 1, 1, 0, 8'h10, 8'h09, 2, 0, 0);
        cmd(1, 0, 0, 1, 8'h00, 8'h10, 2, 0, 0);
        cmd(1, 1, 0, 1, 8'h20, 8'h10, 3, 0, 0);
        cmd(1, 0, 1, 1, 8'h00, 8'h20, 2, 0, 0);
        cmd(1, 0, 1, 0, 8'h00, 8'h10, 1, 0, 0);

        // reset overrides a concurrent push and discards entries
        cmd(1, 1, 0, 0, 8'h44, 8'h10, 2, 0, 0);
        cmd(1, 1, 0, 0, 8'h55, 8'h10, 3, 0, 0);
        cmd(0, 1, 0, 0, 8'h66, 8'h00, 0, 0, 0);
        cmd(1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 1);

        idle();
        repeat (3) @(posedge clk);
        if (q.size() != 0) chk("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
